mult_rr_scheduler: RTL and testbench

- Shares one registered integer multiplier (operand inputs, enable, fixed-latency result) among NREQ requesters.
- Round-robin arbitration over valid/ready request channels; one operation in flight at a time.
- Owns the multiplier's enable/operand sequencing and the return path to the winning requester.
- Sits between the AXI-facing register blocks and the multiplier core.

---
 rtl/mult_rr_scheduler_pkg.sv | 40 ++++
 rtl/mult_rr_scheduler_if.sv | 23 ++
 rtl/mult_rr_scheduler_chk.sv | 19 +
 rtl/mult_rr_scheduler_rr_arbiter.sv | 40 ++++
 rtl/mult_rr_scheduler.sv | 134 +++++++++++++
 tb/tb_mult_rr_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mult_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
// Index width is sized for the largest supported requester count (8).
package mult_sched_pkg;

   localparam int NREQ_MAX = 8;
   localparam int IDW      = $clog2(NREQ_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic           found;
      logic [IDW-1:0] idx;
   } pick_t;

   // First asserted valid bit searching upward from ptr+1, wrapping at nreq.
   function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0] valid,
                                     input logic [IDW-1:0]      ptr,
                                     input int                  nreq);
      pick_t r;
      int    idx;
      r.found = 1'b0;
      r.idx   = '0;
      for (int k = 1; k <= NREQ_MAX; k++) begin
         if (k <= nreq) begin
            idx = (int'(ptr) + k) % nreq;
            if (!r.found && valid[idx]) begin
               r.found = 1'b1;
               r.idx   = idx[IDW-1:0];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mult_rr_scheduler_if.sv
// Requester-side bundle: request channel, response channel and shared result bus.
interface mult_rr_scheduler_if #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [WIDTH-1:0]      rsp_data;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/mult_rr_scheduler_chk.sv
// Protocol checks on the multiplier strobe of the scheduler.
module mult_rr_scheduler_chk
   import mult_sched_pkg::*;
(
   input logic   clk,
   input logic   reset,
   input state_t state,
   input logic   mul_enable
);

   a_enable_only_in_issue: assert property (
      @(posedge clk) disable iff (reset) mul_enable |-> (state == ISSUE)
   );

   a_enable_low_after_reset: assert property (
      @(posedge clk) reset |=> !mul_enable
   );

endmodule

// File: rtl/mult_rr_scheduler_rr_arbiter.sv
// Round-robin grant search; owns the last-winner pointer so that
// requester 0 is favoured first after reset.
module rr_arbiter
   import mult_sched_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] valid,
   input  logic            accept,
   output logic [IDW-1:0]  grant,
   output logic            found
);

   logic [IDW-1:0]      ptr;
   logic [NREQ_MAX-1:0] valid_ext;
   pick_t               pick;

   // Combinational priority search from ptr+1
   always_comb begin
      valid_ext             = '0;
      valid_ext[NREQ-1:0]   = valid;
      pick                  = rr_pick(valid_ext, ptr, NREQ);
      grant                 = pick.idx;
      found                 = pick.found;
   end

   // Pointer tracks the most recent winner
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= IDW'(NREQ - 1);
      end else if (accept) begin
         ptr <= grant;
      end else begin
         ptr <= ptr;
      end
   end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one fixed-latency external multiplier among NREQ requesters with
// round-robin arbitration and a single operation in flight.
module mult_rr_scheduler
   import mult_sched_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NREQ    = 4,
   parameter int MUL_LAT = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   mult_rr_scheduler_if.slave    bus,
   output logic                  mul_enable,
   output logic                  mul_reset_n,
   output logic [WIDTH-1:0]      mul_a,
   output logic [WIDTH-1:0]      mul_b,
   input  logic [WIDTH-1:0]      mul_result,
   output logic                  busy,
   output logic [31:0]           ops_done
);

   localparam int CNTW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [IDW-1:0]   idx;
   logic [CNTW-1:0]  cnt;
   logic [NREQ-1:0]  resp_onehot;
   logic [WIDTH-1:0] resp_data;

   logic [IDW-1:0]   grant;
   logic             found;
   logic             accept;
   logic [NREQ-1:0]  grant_oh;
   logic [NREQ-1:0]  idx_oh;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk    (clk),
      .reset  (reset),
      .valid  (bus.req_valid),
      .accept (accept),
      .grant  (grant),
      .found  (found)
   );

   // Accept decode and one-hot forms of the grant and latched index
   always_comb begin
      accept   = (state == IDLE) && found && !reset;
      grant_oh = '0;
      idx_oh   = '0;
      for (int i = 0; i < NREQ; i++) begin
         grant_oh[i] = (grant == IDW'(i));
         idx_oh[i]   = (idx == IDW'(i));
      end
   end

   assign bus.req_ready = grant_oh & {NREQ{accept}};
   assign bus.rsp_valid = resp_onehot;
   assign bus.rsp_data  = resp_data;
   assign mul_a         = op_a;
   assign mul_b         = op_b;
   assign mul_reset_n   = ~reset;

   // Control FSM: operand latch, multiplier strobe, wait count, response hold
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         op_a        <= '0;
         op_b        <= '0;
         idx         <= '0;
         cnt         <= '0;
         resp_onehot <= '0;
         resp_data   <= '0;
         mul_enable  <= 1'b0;
         busy        <= 1'b0;
         ops_done    <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_a       <= bus.req_a[int'(grant)*WIDTH +: WIDTH];
                  op_b       <= bus.req_b[int'(grant)*WIDTH +: WIDTH];
                  idx        <= grant;
                  mul_enable <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end else begin
                  state      <= IDLE;
               end
            end
            ISSUE: begin
               mul_enable <= 1'b0;
               cnt        <= CNTW'(MUL_LAT - 1);
               state      <= WAIT;
            end
            WAIT: begin
               if (cnt == '0) begin
                  resp_data   <= mul_result;
                  resp_onehot <= idx_oh;
                  state       <= RESP;
               end else begin
                  cnt         <= cnt - CNTW'(1);
               end
            end
            RESP: begin
               // Only the owning requester's ready completes the handshake
               if (|(bus.rsp_ready & idx_oh)) begin
                  resp_onehot <= '0;
                  ops_done    <= ops_done + 32'd1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  state       <= RESP;
               end
            end
            default: begin
               resp_onehot <= '0;
               mul_enable  <= 1'b0;
               busy        <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   mult_rr_scheduler_chk u_chk (
      .clk        (clk),
      .reset      (reset),
      .state      (state),
      .mul_enable (mul_enable)
   );

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Self-checking bench: directed scenarios plus a randomized run against
// a cycle-level reference model of the scheduler's rules.
module tb_mult_rr_scheduler;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int L1 = 1;
   localparam int L3 = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mult_rr_scheduler_if #(.WIDTH(W), .NREQ(N)) bus1 ();
   mult_rr_scheduler_if #(.WIDTH(W), .NREQ(N)) bus3 ();

   logic          en1, rn1, busy1, en3, rn3, busy3;
   logic [W-1:0]  ma1, mb1, mr1, ma3, mb3, mr3, s0, s1, s2;
   logic [31:0]   ops1, ops3;

   mult_rr_scheduler #(.WIDTH(W), .NREQ(N), .MUL_LAT(L1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1), .mul_enable(en1), .mul_reset_n(rn1),
      .mul_a(ma1), .mul_b(mb1), .mul_result(mr1), .busy(busy1), .ops_done(ops1));

   mult_rr_scheduler #(.WIDTH(W), .NREQ(N), .MUL_LAT(L3)) dut3 (
      .clk(clk), .reset(reset), .bus(bus3), .mul_enable(en3), .mul_reset_n(rn3),
      .mul_a(ma3), .mul_b(mb3), .mul_result(mr3), .busy(busy3), .ops_done(ops3));

   // Behavioural multipliers: one-stage and three-stage
   always_ff @(posedge clk) begin
      if (en1) mr1 <= ma1 * mb1;
   end

   always_ff @(posedge clk) begin
      if (en3) s0 <= ma3 * mb3;
      s1 <= s0;
      s2 <= s1;
   end
   assign mr3 = s2;

   int total = 0;
   int bad   = 0;

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      bus1.req_valid = '0;
      bus3.req_valid = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus1.req_valid = 4'hF; bus3.req_valid = 4'hF;
      bus1.rsp_ready = 4'hF; bus3.rsp_ready = 4'hF;
      bus1.req_a = {4{32'd3}}; bus1.req_b = {4{32'd5}};
      bus3.req_a = {4{32'd3}}; bus3.req_b = {4{32'd5}};
      repeat (3) @(negedge clk);
      #1;
      total++; if (bus1.req_ready !== 4'h0) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", bus1.req_ready); end
      total++; if (bus1.rsp_valid !== 4'h0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0000", bus1.rsp_valid); end
      total++; if (en1 !== 1'b0) begin bad++; $display("FAIL reset_mul_enable got=%b want=0", en1); end
      total++; if (rn1 !== 1'b0) begin bad++; $display("FAIL reset_mul_reset_n got=%b want=0", rn1); end
      total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy1); end
      total++; if (ops1 !== 32'd0) begin bad++; $display("FAIL reset_ops_done got=%0d want=0", ops1); end
      total++; if (ma1 !== 32'd0 || mb1 !== 32'd0) begin bad++; $display("FAIL reset_operands got=%h/%h want=0/0", ma1, mb1); end
      total++; if (bus1.rsp_data !== 32'd0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", bus1.rsp_data); end
      reset = 1'b0;
      bus1.req_valid = '0; bus3.req_valid = '0;
      @(negedge clk); #1;
      total++; if (rn1 !== 1'b1) begin bad++; $display("FAIL idle_mul_reset_n got=%b want=1", rn1); end
      total++; if (busy1 !== 1'b0 || bus1.rsp_valid !== 4'h0) begin bad++; $display("FAIL idle_quiet busy=%b rsp_valid=%b want 0/0000", busy1, bus1.rsp_valid); end
   endtask

   task automatic test_single();
      @(negedge clk);
      bus1.req_valid = 4'b0100;
      bus1.req_a[2*W +: W] = 32'd7;
      bus1.req_b[2*W +: W] = 32'd6;
      bus1.rsp_ready = 4'hF;
      #1;
      total++; if (bus1.req_ready !== 4'b0100) begin bad++; $display("FAIL single_req_ready got=%b want=0100", bus1.req_ready); end
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) bus1.req_valid = '0;
         #1;
         total++; if (en1 !== (k == 1)) begin bad++; $display("FAIL single_mul_enable k=%0d got=%b want=%b", k, en1, (k == 1)); end
         total++; if (bus1.rsp_valid !== ((k == 2 + L1) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL single_rsp_valid k=%0d got=%b", k, bus1.rsp_valid); end
         if (k == 2 + L1) begin
            total++; if (bus1.rsp_data !== 32'd42) begin bad++; $display("FAIL single_rsp_data got=%0d want=42", bus1.rsp_data); end
         end
      end
      total++; if (ops1 !== 32'd1) begin bad++; $display("FAIL single_ops_done got=%0d want=1", ops1); end
   endtask

   task automatic test_rotation();
      int got, t, last_t, ei;
      do_reset();
      for (int i = 0; i < N; i++) begin
         bus1.req_a[i*W +: W] = 32'(i + 1);
         bus1.req_b[i*W +: W] = 32'd10;
      end
      bus1.req_valid = 4'hF;
      bus1.rsp_ready = 4'hF;
      got = 0; t = 0; last_t = 0;
      while (got < 5 && t < 80) begin
         @(negedge clk); t++; #1;
         if (bus1.rsp_valid !== 4'h0) begin
            ei = got % N;
            total++; if (bus1.rsp_valid !== oh(ei)) begin bad++; $display("FAIL rot_order n=%0d got=%b want=%b", got, bus1.rsp_valid, oh(ei)); end
            total++; if (bus1.rsp_data !== 32'((ei + 1) * 10)) begin bad++; $display("FAIL rot_data n=%0d got=%0d want=%0d", got, bus1.rsp_data, (ei + 1) * 10); end
            if (got > 0) begin
               total++; if (t - last_t != L1 + 3) begin bad++; $display("FAIL rot_spacing n=%0d got=%0d want=%0d", got, t - last_t, L1 + 3); end
            end
            last_t = t;
            got++;
         end
      end
      total++; if (got != 5) begin bad++; $display("FAIL rot_timeout got=%0d want=5", got); end
      bus1.req_valid = '0;
      repeat (8) @(negedge clk);
   endtask

   // Drives one request on bus1 and reports the response; no checking here.
   task automatic issue_one(input int i, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] d, output logic [N-1:0] rv, output int lat);
      int  t, g;
      bit  acc;
      d = '0; rv = '0; lat = -1; acc = 1'b0; t = 0; g = 0;
      @(negedge clk);
      bus1.req_valid[i] = 1'b1;
      bus1.req_a[i*W +: W] = a;
      bus1.req_b[i*W +: W] = b;
      bus1.rsp_ready = 4'hF;
      while (lat < 0 && g < 40) begin
         #1;
         if (acc && bus1.rsp_valid !== 4'h0) begin
            d = bus1.rsp_data; rv = bus1.rsp_valid; lat = t;
         end else begin
            if (!acc && bus1.req_ready[i]) begin acc = 1'b1; t = 0; end
            @(negedge clk); t++; g++;
            if (acc) bus1.req_valid[i] = 1'b0;
         end
      end
      bus1.req_valid[i] = 1'b0;
   endtask

   task automatic test_truncation();
      logic [31:0]  d;
      logic [N-1:0] rv;
      int           lat;
      issue_one(1, 32'h0001_0000, 32'h0001_0000, d, rv, lat);
      total++; if (d !== 32'h0 || rv !== 4'b0010) begin bad++; $display("FAIL trunc_zero got=%h/%b want=00000000/0010", d, rv); end
      total++; if (lat != 2 + L1) begin bad++; $display("FAIL trunc_latency got=%0d want=%0d", lat, 2 + L1); end
      issue_one(1, 32'hFFFF_FFFF, 32'd2, d, rv, lat);
      total++; if (d !== 32'hFFFF_FFFE || rv !== 4'b0010) begin bad++; $display("FAIL trunc_wrap got=%h/%b want=fffffffe/0010", d, rv); end
   endtask

   task automatic test_backpressure();
      bit acc;
      int g;
      do_reset();
      bus1.rsp_ready = 4'h0;
      bus1.req_valid = 4'b0001;
      bus1.req_a[0 +: W] = 32'd3;
      bus1.req_b[0 +: W] = 32'd5;
      acc = 1'b0; g = 0;
      while (g < 20 && bus1.rsp_valid[0] !== 1'b1) begin
         #1; if (bus1.req_ready[0]) acc = 1'b1;
         @(negedge clk); g++;
         if (acc) bus1.req_valid[0] = 1'b0;
      end
      total++; if (bus1.rsp_valid[0] !== 1'b1) begin bad++; $display("FAIL bp_timeout got=%b want=0001", bus1.rsp_valid); end
      bus1.req_valid[3] = 1'b1;
      bus1.req_a[3*W +: W] = 32'd9;
      bus1.req_b[3*W +: W] = 32'd9;
      bus1.rsp_ready = 4'b1110;
      for (int k = 0; k < 5; k++) begin
         #1;
         total++; if (bus1.rsp_valid !== 4'b0001 || bus1.rsp_data !== 32'd15) begin bad++; $display("FAIL bp_hold k=%0d got=%b/%0d want=0001/15", k, bus1.rsp_valid, bus1.rsp_data); end
         total++; if (busy1 !== 1'b1 || bus1.req_ready !== 4'h0) begin bad++; $display("FAIL bp_block k=%0d busy=%b req_ready=%b want 1/0000", k, busy1, bus1.req_ready); end
         @(negedge clk);
      end
      bus1.rsp_ready = 4'hF;
      @(negedge clk); #1;
      total++; if (bus1.rsp_valid !== 4'h0 || bus1.req_ready !== 4'b1000) begin bad++; $display("FAIL bp_release rsp_valid=%b req_ready=%b want 0000/1000", bus1.rsp_valid, bus1.req_ready); end
      total++; if (ops1 !== 32'd1) begin bad++; $display("FAIL bp_ops_done got=%0d want=1", ops1); end
      @(negedge clk);
      bus1.req_valid[3] = 1'b0;
      g = 0;
      while (g < 10 && bus1.rsp_valid[3] !== 1'b1) begin @(negedge clk); g++; end
      total++; if (bus1.rsp_valid !== 4'b1000 || bus1.rsp_data !== 32'd81) begin bad++; $display("FAIL bp_competitor got=%b/%0d want=1000/81", bus1.rsp_valid, bus1.rsp_data); end
      @(negedge clk);
   endtask

   task automatic test_reset_in_wait();
      @(negedge clk);
      bus1.req_valid = 4'b0100;
      bus1.req_a[2*W +: W] = 32'd4;
      bus1.req_b[2*W +: W] = 32'd4;
      bus1.rsp_ready = 4'hF;
      #1;
      total++; if (bus1.req_ready !== 4'b0100) begin bad++; $display("FAIL rw1_accept got=%b want=0100", bus1.req_ready); end
      @(negedge clk); bus1.req_valid = '0;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         total++; if (bus1.rsp_valid !== 4'h0 || en1 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL rw1_quiet k=%0d rsp_valid=%b en=%b busy=%b want 0000/0/0", k, bus1.rsp_valid, en1, busy1); end
         @(negedge clk);
      end
      bus1.req_valid = 4'hF;
      #1;
      total++; if (bus1.req_ready !== 4'b0001) begin bad++; $display("FAIL rw1_ptr got=%b want=0001", bus1.req_ready); end
      @(negedge clk);
      bus1.req_valid = '0;
   endtask

   task automatic test_latency3();
      do_reset();
      bus3.rsp_ready = 4'hF;
      bus3.req_valid = 4'b0010;
      bus3.req_a[1*W +: W] = 32'd5;
      bus3.req_b[1*W +: W] = 32'd4;
      #1;
      total++; if (bus3.req_ready !== 4'b0010) begin bad++; $display("FAIL l3_accept got=%b want=0010", bus3.req_ready); end
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) bus3.req_valid = '0;
         #1;
         total++; if (en3 !== (k == 1)) begin bad++; $display("FAIL l3_mul_enable k=%0d got=%b want=%b", k, en3, (k == 1)); end
         total++; if (bus3.rsp_valid !== ((k == 2 + L3) ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL l3_rsp_valid k=%0d got=%b", k, bus3.rsp_valid); end
         if (k == 2 + L3) begin
            total++; if (bus3.rsp_data !== 32'd20) begin bad++; $display("FAIL l3_rsp_data got=%0d want=20", bus3.rsp_data); end
         end
      end
      // Reset in the middle of the three-cycle wait
      bus3.req_valid = 4'b0100;
      bus3.req_a[2*W +: W] = 32'd3;
      bus3.req_b[2*W +: W] = 32'd3;
      @(negedge clk); bus3.req_valid = '0;
      @(negedge clk);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         total++; if (bus3.rsp_valid !== 4'h0 || en3 !== 1'b0) begin bad++; $display("FAIL rw3_quiet k=%0d rsp_valid=%b en=%b want 0000/0", k, bus3.rsp_valid, en3); end
         @(negedge clk);
      end
      bus3.req_valid = 4'hF;
      #1;
      total++; if (bus3.req_ready !== 4'b0001) begin bad++; $display("FAIL rw3_ptr got=%b want=0001", bus3.req_ready); end
      @(negedge clk);
      bus3.req_valid = '0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_random();
      bit           pend [N];
      logic [31:0]  pa [N];
      logic [31:0]  pb [N];
      bit           m_free;
      int           m_idx, m_due, m_issue, m_last, pick, j;
      logic [31:0]  m_res, m_ops;
      logic [N-1:0] exp_rv, exp_rr;
      do_reset();
      m_free = 1'b1; m_idx = 0; m_due = 0; m_issue = 0; m_last = N - 1;
      m_res = '0; m_ops = '0;
      for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; end
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         exp_rv = (!m_free && c >= m_due) ? oh(m_idx) : '0;
         total++; if (bus1.rsp_valid !== exp_rv) begin bad++; $display("FAIL rnd_rsp_valid c=%0d got=%b want=%b", c, bus1.rsp_valid, exp_rv); end
         if (exp_rv != '0) begin
            total++; if (bus1.rsp_data !== m_res) begin bad++; $display("FAIL rnd_rsp_data c=%0d got=%h want=%h", c, bus1.rsp_data, m_res); end
         end
         total++; if (en1 !== (!m_free && c == m_issue)) begin bad++; $display("FAIL rnd_mul_enable c=%0d got=%b", c, en1); end
         total++; if (busy1 !== !m_free || ops1 !== m_ops) begin bad++; $display("FAIL rnd_status c=%0d busy=%b ops=%0d want %b/%0d", c, busy1, ops1, !m_free, m_ops); end
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1;
               pa[i]   = $urandom;
               pb[i]   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
            end
            bus1.req_valid[i]    = pend[i];
            bus1.req_a[i*W +: W] = pa[i];
            bus1.req_b[i*W +: W] = pb[i];
         end
         bus1.rsp_ready = 4'($urandom_range(0, 15));
         #1;
         pick = -1;
         for (int k = 1; k <= N; k++) begin
            j = (m_last + k) % N;
            if (pick < 0 && pend[j]) pick = j;
         end
         exp_rr = (m_free && pick >= 0) ? oh(pick) : '0;
         total++; if (bus1.req_ready !== exp_rr) begin bad++; $display("FAIL rnd_req_ready c=%0d got=%b want=%b", c, bus1.req_ready, exp_rr); end
         if (m_free && pick >= 0) begin
            m_free = 1'b0; m_idx = pick; m_last = pick;
            m_issue = c + 1; m_due = c + 2 + L1;
            m_res = pa[pick] * pb[pick];
            pend[pick] = 1'b0;
         end else if (!m_free && c >= m_due && bus1.rsp_ready[m_idx]) begin
            m_free = 1'b1;
            m_ops  = m_ops + 32'd1;
         end
      end
      bus1.req_valid = '0;
      bus1.rsp_ready = 4'hF;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      bus1.req_valid = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.rsp_ready = '0;
      bus3.req_valid = '0; bus3.req_a = '0; bus3.req_b = '0; bus3.rsp_ready = '0;
      test_reset();
      test_single();
      test_rotation();
      test_truncation();
      test_backpressure();
      test_reset_in_wait();
      test_latency3();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
